// File: rtl/rtc_bus_seq_pkg.sv
// Shared types and constants for the RTC multiplexed-bus sequencer.
package rtc_bus_seq_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StASet = 3'd1,
        StAStb = 3'd2,
        StAHld = 3'd3,
        StDSet = 3'd4,
        StDStb = 3'd5,
        StDHld = 3'd6,
        StFin  = 3'd7
    } state_e;

    localparam int unsigned PhaseCycDefault = 10;

    // Value for the lowest-priority mux input (Dato3) when neither select is active.
    localparam logic [7:0] MuxIdleByte = 8'h00;

endpackage

// File: rtl/rtc_bus_seq_phase_timer.sv
// Phase-length counter: counts 0..PHASE_CYC-1 and flags the last cycle of a phase.
module rtc_bus_seq_phase_timer
    import rtc_bus_seq_pkg::*;
#(
    parameter int unsigned PHASE_CYC = PhaseCycDefault
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tc
);

    logic [7:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = clr ? 8'd0 : cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == 8'(PHASE_CYC - 1));

endmodule

// File: rtl/rtc_bus_seq.sv
// Address-then-data sequencer for the RTC multiplexed bus, with registered strobes
// and output-mux selects.
module rtc_bus_seq
    import rtc_bus_seq_pkg::*;
#(
    parameter int unsigned PHASE_CYC = PhaseCycDefault
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] bus_in,
    output logic [7:0] addr_q,
    output logic [7:0] wdata_q,
    output logic       sel_addr,
    output logic       sel_data,
    output logic       bus_oe,
    output logic       cs_n,
    output logic       ad_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done
);

    state_e     state_d, state_q;
    logic       rw_d, rw_q;
    logic [7:0] addr_d, wdata_d;
    logic [7:0] rdata_d, rdata_q;
    logic       sel_addr_d, sel_addr_q, sel_data_d, sel_data_q, bus_oe_d, bus_oe_q;
    logic       cs_n_d, cs_n_q, ad_n_d, ad_n_q, wr_n_d, wr_n_q, rd_n_d, rd_n_q;
    logic       busy_d, busy_q, done_d, done_q;
    logic       tc, timer_clr;

    // The counter stays at zero outside the timed phases so every phase starts fresh.
    assign timer_clr = (state_q == StIdle) || (state_q == StFin) || tc;

    rtc_bus_seq_phase_timer #(
        .PHASE_CYC(PHASE_CYC)
    ) u_phase_timer (
        .clk  (clk),
        .reset(reset),
        .clr  (timer_clr),
        .tc   (tc)
    );

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StASet;
                    rw_d    = rw;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            StFin:   state_d = StIdle;
            default: if (tc) state_d = state_e'(state_q + 3'd1);
        endcase
        if (state_q == StDStb && tc && !rw_q) begin
            rdata_d = bus_in;
        end

        // Outputs are decoded from the next state so the registers line up with it.
        cs_n_d     = 1'b1;
        ad_n_d     = 1'b1;
        wr_n_d     = 1'b1;
        rd_n_d     = 1'b1;
        sel_addr_d = 1'b0;
        sel_data_d = 1'b0;
        bus_oe_d   = 1'b0;
        busy_d     = (state_d != StIdle);
        done_d     = 1'b0;
        case (state_d)
            StASet, StAStb, StAHld: begin
                cs_n_d     = 1'b0;
                ad_n_d     = 1'b0;
                sel_addr_d = 1'b1;
                bus_oe_d   = 1'b1;
                wr_n_d     = (state_d != StAStb);
            end
            StDSet, StDStb, StDHld: begin
                cs_n_d     = 1'b0;
                sel_data_d = rw_d;
                bus_oe_d   = rw_d;
                if (state_d == StDStb) begin
                    wr_n_d = !rw_d;
                    rd_n_d = rw_d;
                end
            end
            StFin:   done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rw_q       <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            cs_n_q     <= 1'b1;
            ad_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            sel_addr_q <= 1'b0;
            sel_data_q <= 1'b0;
            bus_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cs_n_q     <= cs_n_d;
            ad_n_q     <= ad_n_d;
            wr_n_q     <= wr_n_d;
            rd_n_q     <= rd_n_d;
            sel_addr_q <= sel_addr_d;
            sel_data_q <= sel_data_d;
            bus_oe_q   <= bus_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign cs_n     = cs_n_q;
    assign ad_n     = ad_n_q;
    assign wr_n     = wr_n_q;
    assign rd_n     = rd_n_q;
    assign sel_addr = sel_addr_q;
    assign sel_data = sel_data_q;
    assign bus_oe   = bus_oe_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
